// File: rtl/icache_axi_pkg.sv
// ----------------------------------------------------------------------------
// icache_axi_pkg
//   Shared constants for the instruction-cache AXI read refill bridge:
//   AXI burst/response encodings, the one-hot bridge state encoding and the
//   line offset width (16-byte lines).
// ----------------------------------------------------------------------------
package icache_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Byte offset bits inside a 16-byte cache line.
  localparam int LINE_OFF_BITS = 4;

  // One-hot state bit positions.
  localparam int ST_IDLE_BIT = 0;
  localparam int ST_AR_BIT   = 1;
  localparam int ST_R_BIT    = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_AR   = 3'b010,
    ST_R    = 3'b100
  } bridge_state_e;

endpackage

// File: rtl/icache_axi_rd_bridge_watchdog.sv
// ----------------------------------------------------------------------------
// bridge_watchdog
//   Wait-cycle counter with a sticky timeout flag. The counter restarts on
//   clear_i and advances on count_i; once LIMIT consecutive counted cycles
//   have elapsed, timeout_o is raised and held until reset.
// Ports:
//   clock, reset  clock and synchronous active-high reset
//   clear_i       restart the wait count (takes priority over count_i)
//   count_i       one waiting cycle elapsed
//   timeout_o     sticky timeout flag
// ----------------------------------------------------------------------------
module bridge_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic count_i,
  output logic timeout_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      // Saturate so a long stall cannot wrap the counter.
      if (cnt_q != CW'(LIMIT)) cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(LIMIT - 1)) flag_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_o = flag_q;

endmodule

// File: rtl/icache_axi_rd_bridge.sv
// ----------------------------------------------------------------------------
// icache_axi_rd_bridge
//   Refill engine behind the instruction cache. A one-cycle rd_req launches a
//   single AXI4 INCR read burst for the 16-byte line containing rd_addr; the
//   returned beats are streamed to the cache one cycle after each R beat on
//   ret_valid/ret_last/ret_data/ret_err (beat 0 = bytes [7:0], beat 1 =
//   bytes [15:8]).
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   rd_req, rd_addr, rd_rdy cache refill request side
//   ret_valid/last/data/err returned beats to the cache
//   ar*                     AXI read address channel (fixed id/len/size/burst)
//   r*                      AXI read data channel (rready never back-pressures)
//   bridge_timeout          sticky watchdog flag
// Build option:
//   ICACHE_BRIDGE_WATCHDOG_EN  when defined, a bridge_watchdog raises
//   bridge_timeout after TIMEOUT_CYC cycles without progress in AR/R. When
//   undefined, bridge_timeout is tied low. Ports are identical in both builds.
// ----------------------------------------------------------------------------
module icache_axi_rd_bridge
  import icache_axi_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int BEATS       = 2,
  parameter int AXI_ID      = 0,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clock,
  input  logic              reset,
  // cache request side
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rdy,
  // cache return side
  output logic              ret_valid,
  output logic              ret_last,
  output logic [DATA_W-1:0] ret_data,
  output logic              ret_err,
  // AXI AR channel
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  // AXI R channel
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [3:0]        rid,
  // status
  output logic              bridge_timeout
);

  localparam int              CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  bridge_state_e     state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ret_valid_q, ret_valid_d;
  logic              ret_last_q, ret_last_d;
  logic [DATA_W-1:0] ret_data_q, ret_data_d;
  logic              ret_err_q, ret_err_d;

  logic              r_beat;
  logic              final_beat;
  logic              unused_addr_bits;

  // The line offset is dropped when the request is latched.
  assign unused_addr_bits = ^rd_addr[LINE_OFF_BITS-1:0];

  // rd_rdy stays low through the cycle that delivers the final beat, so the
  // cache sees the whole line before it may issue the next miss.
  assign rd_rdy     = state_q[ST_IDLE_BIT] & ~ret_last_q;
  assign r_beat     = state_q[ST_R_BIT] & rvalid;
  assign final_beat = (cnt_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    cnt_d       = cnt_q;
    ret_data_d  = ret_data_q;
    ret_valid_d = 1'b0;
    ret_last_d  = 1'b0;
    ret_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rd_req && rd_rdy) begin
          araddr_d  = {rd_addr[ADDR_W-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
          arvalid_d = 1'b1;
          state_d   = ST_AR;
        end
      end
      ST_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (rvalid) begin
          ret_valid_d = 1'b1;
          ret_data_d  = rdata;
          cnt_d       = cnt_q + CNT_W'(1);
          // An early rlast truncates the line; it is flagged as an error
          // through the rlast/final_beat disagreement.
          ret_err_d   = (rresp != AXI_RESP_OKAY) | (rid != 4'(AXI_ID)) |
                        (rlast != final_beat);
          ret_last_d  = final_beat | rlast;
          if (final_beat || rlast) begin
            rready_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      cnt_q       <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= '0;
      ret_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      cnt_q       <= cnt_d;
      ret_valid_q <= ret_valid_d;
      ret_last_q  <= ret_last_d;
      ret_data_q  <= ret_data_d;
      ret_err_q   <= ret_err_d;
    end
  end

  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arid      = 4'(AXI_ID);
  assign arlen     = 8'(BEATS - 1);
  assign arsize    = 3'($clog2(DATA_W / 8));
  assign arburst   = AXI_BURST_INCR;
  assign rready    = rready_q;
  assign ret_valid = ret_valid_q;
  assign ret_last  = ret_last_q;
  assign ret_data  = ret_data_q;
  assign ret_err   = ret_err_q;

`ifdef ICACHE_BRIDGE_WATCHDOG_EN
  logic wd_clear;
  logic wd_count;

  // Restart on entering AR or R and on every accepted beat; any other
  // cycle spent outside IDLE is a wait cycle.
  assign wd_clear = ((state_d != state_q) && (state_d != ST_IDLE)) || r_beat;
  assign wd_count = ~state_q[ST_IDLE_BIT];

  bridge_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (wd_clear),
    .count_i   (wd_count),
    .timeout_o (bridge_timeout)
  );
`else
  // Tied low; TIMEOUT_CYC is referenced only to keep one parameter list
  // across both builds.
  assign bridge_timeout = 1'b0 & (TIMEOUT_CYC == 0);
`endif

endmodule
